// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared defaults for the scoreboarded register file.
// DATA_W/ADDR_W defaults track the ID-stage register group width.
package reg_file_sb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NRD_DEF    = 2;
    localparam int CNT_W_DEF  = 2;
    localparam int ZERO_REG   = 0;
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: read, issue and write-back signals of the scoreboarded register file.
interface reg_file_sb_if import reg_file_sb_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF
) ();
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  iss_vld;
    logic [ADDR_W-1:0]     iss_addr;
    logic                  iss_rdy;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  err_unexp;
    modport master (
        output rd_addr, iss_vld, iss_addr, wr_en, wr_addr, wr_data,
        input  rd_data, rd_busy, iss_rdy, err_unexp
    );
    modport slave (
        input  rd_addr, iss_vld, iss_addr, wr_en, wr_addr, wr_data,
        output rd_data, rd_busy, iss_rdy, err_unexp
    );
endinterface

// File: rtl/reg_sb_cnt.sv
// reg_sb_cnt: per-register outstanding-write counter, saturating at both ends.
module reg_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             nz
);
    assign full = &cnt;
    assign nz   = |cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (inc && !dec && !full) cnt <= cnt + CNT_W'(1);
        else if (dec && !inc && nz) cnt <= cnt - CNT_W'(1);
    end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with outstanding-write scoreboard for RAW detection.
// Define REG_FILE_BYPASS_EN for write-through reads and same-cycle busy release.
module reg_file_sb import reg_file_sb_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic          clk,
    input logic          rst,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt [DEPTH];
    logic [DEPTH-1:0]  nz, full;
    logic              wr_go, iss_go, err_set, err_q;
    assign wr_go       = bus.wr_en && bus.wr_addr != ADDR_W'(ZERO_REG);
    assign bus.iss_rdy = bus.iss_addr == ADDR_W'(ZERO_REG) || !full[bus.iss_addr];
    assign iss_go      = bus.iss_vld && bus.iss_rdy;
    assign cnt[0]  = '0;
    assign nz[0]   = 1'b0;
    assign full[0] = 1'b0;
    // A same-cycle issue lets the write consume it, so the count nets out without error.
    assign err_set = wr_go && !nz[bus.wr_addr] && !(iss_go && bus.iss_addr == bus.wr_addr);
    assign bus.err_unexp = err_q;
    for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
        logic inc, dec;
        assign inc = iss_go && bus.iss_addr == ADDR_W'(r);
        assign dec = wr_go && bus.wr_addr == ADDR_W'(r) && (nz[r] || inc);
        reg_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc),
            .dec (dec),
            .cnt (cnt[r]),
            .full(full[r]),
            .nz  (nz[r])
        );
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        else if (wr_go) mem[bus.wr_addr] <= bus.wr_data;
    end
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = bus.rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REG_FILE_BYPASS_EN
        logic hit;
        assign hit = !rst && wr_go && bus.wr_addr == a;
        assign bus.rd_data[i*DATA_W +: DATA_W] = hit ? bus.wr_data : mem[a];
        assign bus.rd_busy[i] = nz[a] && !(hit && cnt[a] == CNT_W'(1));
`else
        assign bus.rd_data[i*DATA_W +: DATA_W] = mem[a];
        assign bus.rd_busy[i] = nz[a];
`endif
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed stimulus with queued expectations checked by a negedge monitor.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus ();
    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .CNT_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string       nm;
        int          sel;
        logic [63:0] v;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    localparam int RDATA = 0, BUSY = 1, RDY = 2, ERR = 3;

    task automatic chk(input string nm, input int sel, input logic [63:0] v);
        q.push_back('{nm, sel, v});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [63:0] act;
            e = q.pop_front();
            case (e.sel)
                RDATA:   act = bus.rd_data;
                BUSY:    act = 64'(bus.rd_busy);
                RDY:     act = 64'(bus.iss_rdy);
                default: act = 64'(bus.err_unexp);
            endcase
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
            end
        end
    end

    initial begin
        bus.rd_addr = '0;
        bus.iss_vld = 1'b0;
        bus.iss_addr = '0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        cyc();
        chk("reset_rd_data", RDATA, 64'h0);
        chk("reset_busy", BUSY, 64'h0);
        chk("reset_rdy", RDY, 64'h1);
        chk("reset_err", ERR, 64'h0);
        // issue r3, then see it busy on both ports, then retire it
        cyc(); rst = 1'b0; bus.iss_vld = 1'b1; bus.iss_addr = 5'd3;
        chk("iss_r3_rdy", RDY, 64'h1);
        cyc(); bus.iss_vld = 1'b0; bus.rd_addr = {5'd3, 5'd3};
        chk("r3_busy", BUSY, 64'h3);
        cyc(); wr(5'd3, 32'hDEADBEEF);
`ifdef REG_FILE_BYPASS_EN
        chk("r3_wr_busy", BUSY, 64'h0);
        chk("r3_wr_data", RDATA, 64'hDEADBEEF_DEADBEEF);
`else
        chk("r3_wr_busy", BUSY, 64'h3);
        chk("r3_wr_data", RDATA, 64'h0);
`endif
        cyc(); bus.wr_en = 1'b0;
        chk("r3_done_busy", BUSY, 64'h0);
        chk("r3_done_data", RDATA, 64'hDEADBEEF_DEADBEEF);
        chk("r3_done_err", ERR, 64'h0);
        // saturate r7
        cyc(); bus.iss_vld = 1'b1; bus.iss_addr = 5'd7;
        chk("r7_iss1_rdy", RDY, 64'h1);
        cyc();
        chk("r7_iss2_rdy", RDY, 64'h1);
        cyc();
        chk("r7_iss3_rdy", RDY, 64'h1);
        cyc(); bus.rd_addr = {5'd7, 5'd7}; wr(5'd7, 32'h70);
        chk("r7_full_rdy", RDY, 64'h0);
        chk("r7_full_busy", BUSY, 64'h3);
        cyc(); bus.wr_en = 1'b0;
        chk("r7_after_dec_rdy", RDY, 64'h1);
        cyc(); bus.iss_vld = 1'b0; wr(5'd7, 32'h71);
        chk("r7_refull_busy", BUSY, 64'h3);
        cyc(); wr(5'd7, 32'h72);
        cyc(); wr(5'd7, 32'h73);
        cyc(); bus.wr_en = 1'b0;
        chk("r7_drained_busy", BUSY, 64'h0);
        chk("r7_drained_data", RDATA, 64'h73_00000073);
        chk("r7_drained_err", ERR, 64'h0);
        // issue and write r10 together at cnt 0
        cyc(); bus.iss_vld = 1'b1; bus.iss_addr = 5'd10; wr(5'd10, 32'h55);
        chk("r10_simul_rdy", RDY, 64'h1);
        cyc(); bus.iss_vld = 1'b0; bus.wr_en = 1'b0; bus.rd_addr = {5'd10, 5'd10};
        chk("r10_simul_err", ERR, 64'h0);
        chk("r10_simul_busy", BUSY, 64'h0);
        chk("r10_simul_data", RDATA, 64'h55_00000055);
        // unexpected write to r9
        cyc(); wr(5'd9, 32'h1234);
        chk("r9_err_before", ERR, 64'h0);
        cyc(); bus.wr_en = 1'b0; bus.rd_addr = {5'd9, 5'd9};
        chk("r9_err_set", ERR, 64'h1);
        chk("r9_data", RDATA, 64'h1234_00001234);
        chk("r9_busy", BUSY, 64'h0);
        cyc();
        chk("r9_err_sticky", ERR, 64'h1);
        // register 0
        cyc(); wr(5'd0, 32'hFFFFFFFF); bus.iss_vld = 1'b1; bus.iss_addr = 5'd0;
        chk("r0_iss_rdy", RDY, 64'h1);
        cyc(); bus.wr_en = 1'b0; bus.iss_vld = 1'b0; bus.rd_addr = {5'd0, 5'd0};
        chk("r0_data", RDATA, 64'h0);
        chk("r0_busy", BUSY, 64'h0);
        // write to r4 while port 0 reads it with one outstanding write
        cyc(); bus.iss_vld = 1'b1; bus.iss_addr = 5'd4;
        cyc(); bus.iss_vld = 1'b0; bus.rd_addr = {5'd3, 5'd4}; wr(5'd4, 32'hA5A5A5A5);
`ifdef REG_FILE_BYPASS_EN
        chk("r4_byp_data", RDATA, 64'hDEADBEEF_A5A5A5A5);
        chk("r4_byp_busy", BUSY, 64'h0);
`else
        chk("r4_byp_data", RDATA, 64'hDEADBEEF_00000000);
        chk("r4_byp_busy", BUSY, 64'h1);
`endif
        cyc(); bus.wr_en = 1'b0;
        chk("r4_after_data", RDATA, 64'hDEADBEEF_A5A5A5A5);
        chk("r4_after_busy", BUSY, 64'h0);
        // reset with two outstanding writes to r5
        cyc(); bus.iss_vld = 1'b1; bus.iss_addr = 5'd5;
        cyc();
        cyc(); bus.iss_vld = 1'b0; bus.rd_addr = {5'd5, 5'd5};
        chk("r5_busy", BUSY, 64'h3);
        cyc(); rst = 1'b1; wr(5'd5, 32'h99); bus.iss_vld = 1'b1;
        chk("mid_rst_data", RDATA, 64'h0);
        chk("mid_rst_busy", BUSY, 64'h0);
        chk("mid_rst_rdy", RDY, 64'h1);
        chk("mid_rst_err", ERR, 64'h0);
        cyc(); rst = 1'b0; bus.wr_en = 1'b0; bus.iss_vld = 1'b0; bus.rd_addr = {5'd3, 5'd5};
        chk("post_rst_data", RDATA, 64'h0);
        chk("post_rst_busy", BUSY, 64'h0);
        chk("post_rst_err", ERR, 64'h0);
        chk("post_rst_rdy", RDY, 64'h1);
        cyc();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, need 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
